bcd_display_mux: RTL and testbench
==================================

BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter REFRESH_DIV, default 4, SHALL set the cycles each digit is driven per scan slot (legal range 2..65535).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 load  input  1  strobe; capture bcd0/bcd1 this cycle.
REQ-006 bcd0  input  4  units digit from the BCD digit adder.
REQ-007 bcd1  input  4  tens digit from the BCD digit adder.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 an  output  2  digit enables, active-low; an[0] is units, an[1] is tens.
REQ-010 err  output  1  sticky flag; set when a captured digit exceeds 9.

Function
REQ-011 On the rising edge where load=1, the block SHALL capture bcd0/bcd1 into hold registers; the new value is displayed from the next slot boundary.
REQ-012 States SHALL be IDLE, GAP0, DIG0, GAP1, DIG1.
- IDLE: segments blank, no digit enabled.
- GAP states: anti-ghost dead time, segments blank and no digit enabled.
REQ-013 Transitions SHALL be as follows.
- IDLE -> GAP0 on load.
- GAP0 -> DIG0 after 1 cycle.
- DIG0 -> GAP1 after REFRESH_DIV cycles.
- GAP1 -> DIG1 after 1 cycle.
- DIG1 -> GAP0 after REFRESH_DIV cycles.
REQ-014 In DIG0, an SHALL be 2'b10 and seg SHALL show the held units digit.
REQ-015 In DIG1, an SHALL be 2'b01 and seg SHALL show the held tens digit.
REQ-016 Digit encodings SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-017 A held digit value 10..15 SHALL display E (0000110).
REQ-018 Leading-zero blanking: in DIG1, when the held tens digit is 0, seg SHALL be 1111111 while an is still 2'b01.
REQ-019 seg and an SHALL be registered outputs: they change exactly one cycle after the state/counter transition that selects them.
REQ-020 A load during any non-IDLE state SHALL update the hold registers without restarting or perturbing the scan sequence or slot counter.
REQ-021 A load coinciding with a slot boundary SHALL make the new value visible in the slot that begins on that boundary.
REQ-022 err SHALL set on the capture edge of any digit above 9 and clear only on reset.
REQ-023 The slot counter SHALL be 16 bits, reload to 0 on every state change, and never wrap inside a slot.

Reset
REQ-024 While rst=1, the state SHALL be IDLE, hold registers and counter 0, seg=1111111, an=2'b11 and err=0, all asynchronously.
REQ-025 Reset asserted mid-scan SHALL force IDLE immediately.
REQ-026 After reset release, the block SHALL stay in IDLE until the first load.

Structure
REQ-027 The state encodings, the segment constants (blank, E, digits 0-9) and the REFRESH_DIV default SHALL live in a shared package seg_pkg.
REQ-028 A single combinational sub-module bcd_to_seg (4-bit in, 7-bit active-low out) SHALL perform decoding, instantiated once and fed by a digit-select mux.

Verification
REQ-029 Reset: assert rst mid-DIG1 -> seg=1111111, an=11 and err=0 within the same cycle; the block remains blank until load.
REQ-030 Basic scan: load bcd1=1, bcd0=4, REFRESH_DIV=4 -> the following sequence repeats indefinitely:
- 1 blank cycle;
- 4 cycles with an=10, seg=0011001;
- 1 blank cycle;
- 4 cycles with an=01, seg=1111001.
REQ-031 Leading zero: load bcd1=0, bcd0=7 -> DIG0 shows 1111000; DIG1 shows 1111111 with an=01.
REQ-032 Invalid digit: load bcd1=0, bcd0=12 -> DIG0 shows 0000110 and err=1; a later load of 0/3 leaves err=1.
REQ-033 Mid-scan load: during the 2nd DIG0 cycle, load 1/8 over a held 1/5 -> the current DIG0 slot continues showing 5 until its end; the next DIG0 slot shows 8; slot lengths are unchanged.
REQ-034 Boundary load: assert load on the last DIG1 cycle -> the next DIG0 slot shows the new units digit.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the two-digit BCD seven-segment scanner:
// FSM states, active-low segment patterns and digit-enable codes.
package seg_pkg;

    localparam int unsigned REFRESH_DIV_DEFAULT = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP0 = 3'd1,
        ST_DIG0 = 3'd2,
        ST_GAP1 = 3'd3,
        ST_DIG1 = 3'd4
    } scan_state_e;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder;
// codes 10..15 render as the letter E.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit lookup; anything outside 0..9 falls through to E.
    always_comb begin
        seg = SEG_E;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed seven-segment driver with blank gaps between digits,
// leading-zero blanking on the tens digit and a sticky invalid-digit flag.
module bcd_display_mux
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam logic [15:0] LAST_CNT = 16'(REFRESH_DIV - 32'd1);

    scan_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  hold0_q, hold0_d;
    logic [3:0]  hold1_q, hold1_d;
    logic [3:0]  disp_q, disp_d;
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  an_q, an_d;
    logic        err_q, err_d;
    logic [6:0]  dec_seg;

    // Scan sequencing and slot counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_GAP0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP0: state_d = ST_DIG0;
            ST_DIG0: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_GAP1;
                end else begin
                    state_d = ST_DIG0;
                end
            end
            ST_GAP1: state_d = ST_DIG1;
            ST_DIG1: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_GAP0;
                end else begin
                    state_d = ST_DIG1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else if ((state_q == ST_DIG0) || (state_q == ST_DIG1)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
    end

    // Hold registers, per-slot digit snapshot and sticky error.
    // The snapshot is taken on the gap->digit edge from hold_d, so a load on
    // that very edge is shown, while later loads wait for the next slot.
    always_comb begin
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        err_d   = err_q;
        if (load) begin
            hold0_d = bcd0;
            hold1_d = bcd1;
            err_d   = err_q | digit_invalid(bcd0) | digit_invalid(bcd1);
        end else begin
            err_d   = err_q;
        end

        disp_d = disp_q;
        case (state_q)
            ST_GAP0: disp_d = hold0_d;
            ST_GAP1: disp_d = hold1_d;
            default: disp_d = disp_q;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (disp_q),
        .seg (dec_seg)
    );

    // Output pattern for the current state, registered one cycle later.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        case (state_q)
            ST_DIG0: begin
                seg_d = dec_seg;
                an_d  = AN_UNITS;
            end
            ST_DIG1: begin
                an_d = AN_TENS;
                if (disp_q == 4'd0) begin
                    seg_d = SEG_BLANK;
                end else begin
                    seg_d = dec_seg;
                end
            end
            default: begin
                seg_d = SEG_BLANK;
                an_d  = AN_OFF;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            hold0_q <= 4'd0;
            hold1_q <= 4'd0;
            disp_q  <= 4'd0;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_OFF;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            err_q   <= err_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Self-checking bench for bcd_display_mux: table of digit pairs run through
// full scans, plus mid-scan load, boundary load, sticky error and reset cases.
module tb_bcd_display_mux;

    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       load = 1'b0;
    logic [3:0] bcd0 = 4'd0;
    logic [3:0] bcd1 = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] seg;
        logic [1:0] an;
        logic       err;
        int         p;
    } exp_t;

    typedef struct {
        logic [3:0] b1;
        logic [3:0] b0;
        logic [6:0] us;
        logic [6:0] ts;
        logic       e;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];

    bcd_display_mux #(.REFRESH_DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .bcd0 (bcd0),
        .bcd1 (bcd1),
        .seg  (seg),
        .an   (an),
        .err  (err)
    );

    always #5 clk = ~clk;

    // p counts clock edges since the load edge (p=0). With REFRESH_DIV=4 the
    // output period is 10: blank, 4 units, blank, 4 tens, starting at p=1.
    function automatic int kind_at(input int p);
        int q;
        if (p <= 0) return 0;
        q = (p - 1) % 10;
        if (q >= 1 && q <= 4) return 1;
        if (q >= 6) return 2;
        return 0;
    endfunction

    task automatic compare_out(input string name);
        exp_t x;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            x = sb_q.pop_front();
            if ({seg, an, err} !== {x.seg, x.an, x.err}) begin
                errors++;
                $display("FAIL %s p=%0d: got seg=%b an=%b err=%b, want seg=%b an=%b err=%b",
                         name, x.p, seg, an, err, x.seg, x.an, x.err);
            end
        end
    endtask

    task automatic step(input string name, input int p, input logic ld,
                        input logic [3:0] b1, input logic [3:0] b0,
                        input logic [6:0] us, input logic [6:0] ts, input logic e);
        exp_t x;
        int   k;
        @(negedge clk);
        load = ld;
        bcd1 = b1;
        bcd0 = b0;
        k = kind_at(p);
        x.seg = (k == 1) ? us : ((k == 2) ? ts : SB);
        x.an  = (k == 1) ? 2'b10 : ((k == 2) ? 2'b01 : 2'b11);
        x.err = e;
        x.p   = p;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        load = 1'b0;
        compare_out(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'd1,  4'd4,  S4, S1, 1'b0};
        vecs[1] = '{4'd0,  4'd7,  S7, SB, 1'b0};
        vecs[2] = '{4'd0,  4'd12, SE, SB, 1'b1};
        vecs[3] = '{4'd9,  4'd0,  S0, S9, 1'b0};
        vecs[4] = '{4'd2,  4'd5,  S5, S2, 1'b0};
        vecs[5] = '{4'd15, 4'd3,  S3, SE, 1'b1};
        vecs[6] = '{4'd8,  4'd6,  S6, S8, 1'b0};

        // Table: reset, idle, load, two full scan periods.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int i = 0; i < 3; i++) step("idle", 0, 1'b0, 4'd0, 4'd0, SB, SB, 1'b0);
            step("load", 0, 1'b1, vecs[v].b1, vecs[v].b0, vecs[v].us, vecs[v].ts, vecs[v].e);
            for (int p = 1; p < 22; p++)
                step("scan", p, 1'b0, 4'd0, 4'd0, vecs[v].us, vecs[v].ts, vecs[v].e);
        end

        // Load 1/8 over 1/5 in the 2nd DIG0 cycle: current slot keeps 5.
        do_reset();
        step("mid_load", 0, 1'b1, 4'd1, 4'd5, S5, S1, 1'b0);
        for (int p = 1; p < 22; p++)
            step("mid_load", p, (p == 3), 4'd1, 4'd8, (p < 11) ? S5 : S8, S1, 1'b0);

        // Load on the last DIG1 cycle (p=10) and on the GAP0->DIG0 edge (p=11).
        for (int lp = 10; lp <= 11; lp++) begin
            do_reset();
            step("bound_load", 0, 1'b1, 4'd1, 4'd4, S4, S1, 1'b0);
            for (int p = 1; p < 22; p++)
                step("bound_load", p, (p == lp), 4'd2, 4'd6,
                     (p < 11) ? S4 : S6, (p < 12) ? S1 : S2, 1'b0);
        end

        // Sticky error survives a later valid load.
        do_reset();
        step("err_sticky", 0, 1'b1, 4'd0, 4'd12, SE, SB, 1'b1);
        for (int p = 1; p < 22; p++)
            step("err_sticky", p, (p == 5), 4'd0, 4'd3, (p < 11) ? SE : S3, SB, 1'b1);

        // Reset asserted mid-DIG1 blanks everything without a clock edge.
        do_reset();
        step("pre_rst", 0, 1'b1, 4'd12, 4'd4, S4, SE, 1'b1);
        for (int p = 1; p < 9; p++)
            step("pre_rst", p, 1'b0, 4'd0, 4'd0, S4, SE, 1'b1);
        begin
            exp_t x;
            @(negedge clk);
            #2;
            rst = 1'b1;
            #1;
            x.seg = SB; x.an = 2'b11; x.err = 1'b0; x.p = -1;
            sb_q.push_back(x);
            compare_out("async_rst");
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
        for (int i = 0; i < 5; i++) step("post_rst_idle", 0, 1'b0, 4'd0, 4'd0, SB, SB, 1'b0);
        step("post_rst_load", 0, 1'b1, 4'd1, 4'd4, S4, S1, 1'b0);
        for (int p = 1; p < 12; p++)
            step("post_rst_scan", p, 1'b0, 4'd0, 4'd0, S4, S1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
